// File: rtl/me_result_collector.sv
// ============================================================================
// me_result_collector
// ----------------------------------------------------------------------------
// Downstream stage of the me266 motion-estimation core. Each block produces a
// serial result burst framed by sign_sad: the SAD arrives MSB first over
// SAD_W framed cycles. The MV x/y components arrive MSB first in the first
// MV_W framed cycles. This block deserializes the burst and checks its length.
// Well-formed results go into a small show-ahead FIFO that the result writer
// drains through a valid/ready handshake.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active-high
//   sign_sad   burst frame, high for exactly SAD_W cycles per block
//   sad_out    SAD serial bit, MSB first
//   x_out      MV x serial bit, MSB first, first MV_W framed cycles
//   y_out      MV y serial bit, MSB first, first MV_W framed cycles
//   res_valid  FIFO head holds a result
//   res_ready  consumer takes the head when res_valid && res_ready
//   res_sad    head SAD (unsigned)
//   res_mvx    head MV x (signed, -7..+8)
//   res_mvy    head MV y (signed, -7..+8)
//   res_idx    head block index (sequence number of well-formed bursts)
//   fifo_full  FIFO holds FIFO_DEPTH entries
//   err_len    sticky: a burst of the wrong length was seen
//   err_ovf    sticky: a good result was dropped because the FIFO was full
//   err_clr    synchronous clear of both sticky flags
// ============================================================================
module me_result_collector #(
    parameter int SAD_W      = 14,
    parameter int MV_W       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sign_sad,
    input  logic             sad_out,
    input  logic             x_out,
    input  logic             y_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SAD_W-1:0] res_sad,
    output logic [MV_W:0]    res_mvx,
    output logic [MV_W:0]    res_mvy,
    output logic [IDX_W-1:0] res_idx,
    output logic             fifo_full,
    output logic             err_len,
    output logic             err_ovf,
    input  logic             err_clr
);

    localparam int CNT_W = $clog2(SAD_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAD_W);
    localparam logic [CNT_W-1:0] CNT_MV   = CNT_W'(MV_W);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    // The most negative serial code stands for +8, not -8.
    localparam logic [MV_W-1:0]  MV_POS_MAX = {1'b1, {(MV_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_bitCnt;
    logic [CNT_W-1:0]   w_bitCntNext;
    logic               w_commit;
    logic               w_lenErr;

    logic [SAD_W-1:0]   r_sadSr;
    logic [MV_W-1:0]    r_xSr;
    logic [MV_W-1:0]    r_ySr;
    logic [IDX_W-1:0]   r_idxCnt;

    logic [SAD_W-1:0]   r_memSad [FIFO_DEPTH];
    logic [MV_W:0]      r_memMvx [FIFO_DEPTH];
    logic [MV_W:0]      r_memMvy [FIFO_DEPTH];
    logic [IDX_W-1:0]   r_memIdx [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [OCC_W-1:0]   r_occ;

    logic [SAD_W-1:0]   r_headSad;
    logic [MV_W:0]      r_headMvx;
    logic [MV_W:0]      r_headMvy;
    logic [IDX_W-1:0]   r_headIdx;

    logic               r_errLen;
    logic               r_errOvf;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [MV_W:0]      w_mvx;
    logic [MV_W:0]      w_mvy;
    logic [PTR_W-1:0]   w_rdNext;
    logic [OCC_W-1:0]   w_occNext;

    // State register for the burst framing FSM together with its bit counter.
    // An asynchronous reset in the middle of a burst drops the burst, because
    // the FSM returns to IDLE with a zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_bitCnt <= w_bitCntNext;
        end
    end

    // Next-state logic for the framing FSM.
    // A burst that is still high after SAD_W bits goes to DRAIN. DRAIN waits
    // for the frame to fall, so the tail of an over-long burst cannot start a
    // bogus new burst. A burst that ends early is discarded in SHIFT.
    // w_commit marks the edge where a burst of exactly SAD_W bits closes.
    always_comb begin
        w_stateNext  = r_state;
        w_bitCntNext = r_bitCnt;
        w_commit     = 1'b0;
        w_lenErr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sign_sad) begin
                    w_stateNext  = ST_SHIFT;
                    w_bitCntNext = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (sign_sad) begin
                    if (r_bitCnt == CNT_FULL) begin
                        w_stateNext  = ST_DRAIN;
                        w_bitCntNext = '0;
                        w_lenErr     = 1'b1;
                    end else begin
                        w_bitCntNext = r_bitCnt + CNT_W'(1);
                    end
                end else begin
                    if (r_bitCnt == CNT_FULL) begin
                        w_commit = 1'b1;
                    end else begin
                        w_lenErr = 1'b1;
                    end
                    w_stateNext  = ST_IDLE;
                    w_bitCntNext = '0;
                end
            end
            ST_DRAIN: begin
                if (!sign_sad) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext  = ST_IDLE;
                w_bitCntNext = '0;
            end
        endcase
    end

    // Serial-to-parallel shift registers.
    // The SAD shifts on every framed cycle. After exactly SAD_W bits, only the
    // current burst is left in the register, so it never needs clearing.
    // The MV registers shift only while the count is below MV_W, which keeps
    // the leading MV_W bits of the burst. The count is zero in both IDLE and
    // DRAIN, so leftover shifting in DRAIN is pushed out by the next burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sadSr <= '0;
            r_xSr   <= '0;
            r_ySr   <= '0;
        end else if (sign_sad) begin
            r_sadSr <= {r_sadSr[SAD_W-2:0], sad_out};
            if (r_bitCnt < CNT_MV) begin
                r_xSr <= {r_xSr[MV_W-2:0], x_out};
                r_ySr <= {r_ySr[MV_W-2:0], y_out};
            end
        end
    end

    // Block index counter.
    // It counts every well-formed burst, so a result dropped on overflow
    // still uses up its sequence number and leaves a visible gap in res_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idxCnt <= '0;
        end else if (w_commit) begin
            r_idxCnt <= r_idxCnt + IDX_W'(1);
        end
    end

    // FIFO handshake and the next-cycle pointer and occupancy values.
    // A commit into a full FIFO is still accepted when the consumer pops on
    // the same edge. MV codes are widened to MV_W+1 bits here, with the
    // 1000 code mapped to +8.
    always_comb begin
        w_empty  = (r_occ == '0);
        w_full   = (r_occ == OCC_FULL);
        w_pop    = res_ready && !w_empty;
        w_push   = w_commit && (!w_full || w_pop);
        w_drop   = w_commit && w_full && !w_pop;
        w_mvx    = (r_xSr == MV_POS_MAX) ? {1'b0, r_xSr} : {r_xSr[MV_W-1], r_xSr};
        w_mvy    = (r_ySr == MV_POS_MAX) ? {1'b0, r_ySr} : {r_ySr[MV_W-1], r_ySr};
        w_rdNext = w_pop ? (r_rdPtr + PTR_W'(1)) : r_rdPtr;
        case ({w_push, w_pop})
            2'b10:   w_occNext = r_occ + OCC_W'(1);
            2'b01:   w_occNext = r_occ - OCC_W'(1);
            default: w_occNext = r_occ;
        endcase
    end

    // FIFO storage and pointers.
    // FIFO_DEPTH is a power of two, so the pointers wrap without any extra
    // logic. The occupancy counter tells a full FIFO apart from an empty one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_memSad[i] <= '0;
                r_memMvx[i] <= '0;
                r_memMvy[i] <= '0;
                r_memIdx[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_push) begin
                r_memSad[r_wrPtr] <= r_sadSr;
                r_memMvx[r_wrPtr] <= w_mvx;
                r_memMvy[r_wrPtr] <= w_mvy;
                r_memIdx[r_wrPtr] <= r_idxCnt;
                r_wrPtr           <= r_wrPtr + PTR_W'(1);
            end
            r_rdPtr <= w_rdNext;
            r_occ   <= w_occNext;
        end
    end

    // Registered head outputs.
    // The head is loaded whenever the FIFO will be non-empty after this edge.
    // When it will be empty, the registers keep the last result shown, so the
    // outputs do not reveal stale slots. If the next head is the entry being
    // written on this same edge, that data is taken straight from the write
    // path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_headSad <= '0;
            r_headMvx <= '0;
            r_headMvy <= '0;
            r_headIdx <= '0;
        end else if (w_occNext != '0) begin
            if (w_push && (r_wrPtr == w_rdNext)) begin
                r_headSad <= r_sadSr;
                r_headMvx <= w_mvx;
                r_headMvy <= w_mvy;
                r_headIdx <= r_idxCnt;
            end else begin
                r_headSad <= r_memSad[w_rdNext];
                r_headMvx <= r_memMvx[w_rdNext];
                r_headMvy <= r_memMvy[w_rdNext];
                r_headIdx <= r_memIdx[w_rdNext];
            end
        end
    end

    // Sticky error flags.
    // If a new error arrives on the same edge as err_clr, the set wins, so
    // the error is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errLen <= 1'b0;
            r_errOvf <= 1'b0;
        end else begin
            r_errLen <= (r_errLen && !err_clr) || w_lenErr;
            r_errOvf <= (r_errOvf && !err_clr) || w_drop;
        end
    end

    assign res_valid = (r_occ != '0);
    assign fifo_full = (r_occ == OCC_FULL);
    assign res_sad   = r_headSad;
    assign res_mvx   = r_headMvx;
    assign res_mvy   = r_headMvy;
    assign res_idx   = r_headIdx;
    assign err_len   = r_errLen;
    assign err_ovf   = r_errOvf;

endmodule

// File: tb/tb_me_result_collector.sv
// ============================================================================
// tb_me_result_collector
// ----------------------------------------------------------------------------
// Self-checking bench for me_result_collector. A table of single bursts with
// hand-converted MV values is followed by directed sequences for overflow,
// bad burst lengths, push/pop on a full FIFO, and reset mid-burst.
// Inputs are driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_me_result_collector;

    localparam int SAD_W = 14;
    localparam int MV_W  = 4;
    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sign_sad = 1'b0;
    logic             sad_out = 1'b0;
    logic             x_out = 1'b0;
    logic             y_out = 1'b0;
    logic             res_ready = 1'b0;
    logic             err_clr = 1'b0;
    logic             res_valid;
    logic [SAD_W-1:0] res_sad;
    logic [MV_W:0]    res_mvx;
    logic [MV_W:0]    res_mvy;
    logic [IDX_W-1:0] res_idx;
    logic             fifo_full;
    logic             err_len;
    logic             err_ovf;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  mvx;
        logic [MV_W-1:0]  mvy;
        logic [MV_W:0]    expMvx;
        logic [MV_W:0]    expMvy;
    } vecT;

    vecT vecs [5];

    me_result_collector #(
        .SAD_W(SAD_W), .MV_W(MV_W), .FIFO_DEPTH(4), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .sign_sad(sign_sad), .sad_out(sad_out),
        .x_out(x_out), .y_out(y_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_sad(res_sad), .res_mvx(res_mvx),
        .res_mvy(res_mvy), .res_idx(res_idx), .fifo_full(fifo_full),
        .err_len(err_len), .err_ovf(err_ovf), .err_clr(err_clr)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one value against its expected value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Check every head field at once.
    task automatic checkHead(input string name, input logic [SAD_W-1:0] sad,
                             input logic [MV_W:0] mvx, input logic [MV_W:0] mvy,
                             input logic [IDX_W-1:0] idx);
        checkOutput({name, ".valid"}, 32'(res_valid), 32'd1);
        checkOutput({name, ".sad"},   32'(res_sad),   32'(sad));
        checkOutput({name, ".mvx"},   32'(res_mvx),   32'(mvx));
        checkOutput({name, ".mvy"},   32'(res_mvy),   32'(mvy));
        checkOutput({name, ".idx"},   32'(res_idx),   32'(idx));
    endtask

    // Send one framed burst of len cycles, MSB first, then drop the frame.
    // The frame falls at the negedge after the last bit, so two calls in a row
    // give exactly one low cycle between bursts.
    task automatic applyStimulus(input int len, input logic [SAD_W-1:0] sad,
                                 input logic [MV_W-1:0] mvx, input logic [MV_W-1:0] mvy);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            sign_sad = 1'b1;
            sad_out  = 1'b0;
            x_out    = 1'b0;
            y_out    = 1'b0;
            if (i < SAD_W) sad_out = sad[SAD_W-1-i];
            if (i < MV_W) begin
                x_out = mvx[MV_W-1-i];
                y_out = mvy[MV_W-1-i];
            end
        end
        @(negedge clk);
        sign_sad = 1'b0;
        sad_out  = 1'b0;
        x_out    = 1'b0;
        y_out    = 1'b0;
    endtask

    // Pulse reset for one cycle and clear every input.
    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        sign_sad  = 1'b0;
        res_ready = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Main test sequence.
    initial begin
        vecs[0] = '{sad: 14'd1234,  mvx: 4'b1000, mvy: 4'b1101, expMvx: 5'b01000, expMvy: 5'b11101};
        vecs[1] = '{sad: 14'd0,     mvx: 4'b0000, mvy: 4'b0111, expMvx: 5'b00000, expMvy: 5'b00111};
        vecs[2] = '{sad: 14'd16383, mvx: 4'b1111, mvy: 4'b1001, expMvx: 5'b11111, expMvy: 5'b11001};
        vecs[3] = '{sad: 14'd8192,  mvx: 4'b0001, mvy: 4'b1000, expMvx: 5'b00001, expMvy: 5'b01000};
        vecs[4] = '{sad: 14'd1,     mvx: 4'b0110, mvy: 4'b1010, expMvx: 5'b00110, expMvy: 5'b11010};

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst.valid", 32'(res_valid), 32'd0);
        checkOutput("rst.full",  32'(fifo_full), 32'd0);
        checkOutput("rst.errLen", 32'(err_len), 32'd0);
        checkOutput("rst.errOvf", 32'(err_ovf), 32'd0);
        checkOutput("rst.sad", 32'(res_sad), 32'd0);
        checkOutput("rst.mvx", 32'(res_mvx), 32'd0);
        checkOutput("rst.mvy", 32'(res_mvy), 32'd0);
        checkOutput("rst.idx", 32'(res_idx), 32'd0);

        // Table of single bursts: the result appears one cycle after the
        // commit edge, is popped on the next edge, and is then held.
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(SAD_W, vecs[i].sad, vecs[i].mvx, vecs[i].mvy);
            @(negedge clk);
            checkHead($sformatf("vec%0d", i), vecs[i].sad, vecs[i].expMvx,
                      vecs[i].expMvy, IDX_W'(i));
            @(negedge clk);
            checkOutput($sformatf("vec%0d.popped", i), 32'(res_valid), 32'd0);
            checkOutput($sformatf("vec%0d.hold", i), 32'(res_sad), 32'(vecs[i].sad));
        end
        checkOutput("vec.errLen", 32'(err_len), 32'd0);

        // Overflow: five back-to-back bursts with no consumer. The fifth
        // burst is dropped but still uses up index 4.
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(SAD_W, SAD_W'(100 + k), 4'b0001, 4'b0010);
        @(negedge clk);
        checkOutput("ovf.full", 32'(fifo_full), 32'd1);
        checkOutput("ovf.errOvf", 32'(err_ovf), 32'd1);
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkHead($sformatf("ovf.drain%0d", k), SAD_W'(100 + k), 5'b00001, 5'b00010, IDX_W'(k));
            @(negedge clk);
        end
        checkOutput("ovf.empty", 32'(res_valid), 32'd0);
        checkOutput("ovf.notFull", 32'(fifo_full), 32'd0);
        applyStimulus(SAD_W, 14'd555, 4'b0011, 4'b0100);
        @(negedge clk);
        checkHead("ovf.next", 14'd555, 5'b00011, 5'b00100, 16'd5);
        checkOutput("ovf.sticky", 32'(err_ovf), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("ovf.cleared", 32'(err_ovf), 32'd0);

        // A short burst is rejected, and the good burst after it gets index 0.
        doReset();
        applyStimulus(13, 14'd3000, 4'b0101, 4'b0101);
        applyStimulus(SAD_W, 14'd777, 4'b1110, 4'b0010);
        @(negedge clk);
        checkOutput("short.errLen", 32'(err_len), 32'd1);
        checkOutput("short.errOvf", 32'(err_ovf), 32'd0);
        checkHead("short.good", 14'd777, 5'b11110, 5'b00010, 16'd0);

        // A long burst is drained and ignored, and the next burst is accepted.
        doReset();
        applyStimulus(20, 14'd2222, 4'b0111, 4'b0111);
        @(negedge clk);
        checkOutput("long.errLen", 32'(err_len), 32'd1);
        checkOutput("long.none", 32'(res_valid), 32'd0);
        applyStimulus(SAD_W, 14'd4321, 4'b0011, 4'b1100);
        @(negedge clk);
        checkHead("long.good", 14'd4321, 5'b00011, 5'b11100, 16'd0);

        // Full FIFO with a commit on the same edge as a pop: the push is kept.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(SAD_W, SAD_W'(200 + k), 4'b0000, 4'b0000);
        applyStimulus(SAD_W, 14'd204, 4'b0000, 4'b0000);
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("coin.errOvf", 32'(err_ovf), 32'd0);
        checkOutput("coin.full", 32'(fifo_full), 32'd1);
        for (int k = 1; k < 5; k++) begin
            checkHead($sformatf("coin.drain%0d", k), SAD_W'(200 + k), 5'b00000, 5'b00000, IDX_W'(k));
            @(negedge clk);
        end
        checkOutput("coin.empty", 32'(res_valid), 32'd0);

        // Reset partway through a burst while a result and an error are pending.
        doReset();
        applyStimulus(SAD_W, 14'd1234, 4'b1000, 4'b1101);
        applyStimulus(13, 14'd1, 4'b0001, 4'b0001);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sign_sad = 1'b1;
            sad_out  = 1'b1;
        end
        @(negedge clk);
        rst      = 1'b1;
        sign_sad = 1'b0;
        sad_out  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midRst.valid", 32'(res_valid), 32'd0);
        checkOutput("midRst.sad", 32'(res_sad), 32'd0);
        checkOutput("midRst.mvx", 32'(res_mvx), 32'd0);
        checkOutput("midRst.idx", 32'(res_idx), 32'd0);
        checkOutput("midRst.errLen", 32'(err_len), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("midRst.noResult", 32'(res_valid), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("clr.errLen", 32'(err_len), 32'd0);
        checkOutput("clr.errOvf", 32'(err_ovf), 32'd0);
        res_ready = 1'b1;
        applyStimulus(SAD_W, 14'd99, 4'b0010, 4'b1110);
        @(negedge clk);
        checkHead("midRst.after", 14'd99, 5'b00010, 5'b11110, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
